// File: rtl/accel_pkg.sv
// Shared constants and helpers for the accelerator datapath blocks.
// Used for elaboration-time sizing and parameter range checks.
package accel_pkg;

    localparam int MAX_DELAY_STAGES = 64;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline slot: a valid bit plus its payload register.
// Payload only loads when a valid entry arrives, so bubbles keep stale data.
module elastic_stage #(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  adv,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] dout
);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (adv) begin
            valid <= in_valid;
            if (in_valid) dout <= din;
        end
    end

endmodule

// File: rtl/elastic_delay_line.sv
// Elastic N-stage delay line with valid/ready backpressure and bubble collapse.
// NUM_STAGES=0 degenerates to a combinational pass-through.
module elastic_delay_line
    import accel_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DATA_WIDTH = 2,
    localparam int CNT_W = (NUM_STAGES == 0) ? 1 : clog2(NUM_STAGES + 1)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FLUSH,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic [CNT_W-1:0]      OCCUPANCY,
    output logic                  FULL
);

    if (NUM_STAGES > MAX_DELAY_STAGES) begin : g_range_chk
        $fatal(1, "elastic_delay_line: NUM_STAGES exceeds MAX_DELAY_STAGES");
    end

    if (NUM_STAGES == 0) begin : g_bypass
        assign DOUT      = DIN;
        assign OUT_VALID = IN_VALID & ~FLUSH;
        assign IN_READY  = OUT_READY & ~FLUSH;
        assign OCCUPANCY = '0;
        assign FULL      = 1'b1;
    end else begin : g_pipe
        localparam int N = NUM_STAGES;

        logic [N-1:0]          v;
        logic [N-1:0]          adv;
        logic [N-1:0]          st_adv;
        logic [N-1:0]          st_in;
        logic [DATA_WIDTH-1:0] d      [N];
        logic [DATA_WIDTH-1:0] st_din [N];
        logic                  in_xfer;
        logic                  out_xfer;
        logic [CNT_W-1:0]      occ;

        assign IN_READY  = adv[0] & ~FLUSH;
        assign OUT_VALID = v[N-1] & ~FLUSH;
        assign DOUT      = d[N-1];
        assign in_xfer   = IN_VALID & IN_READY;
        assign out_xfer  = OUT_VALID & OUT_READY;

        for (genvar k = 0; k < N; k++) begin : g_stage
            // A stage may move if any slot at or after it is empty.
            assign adv[k]    = OUT_READY | ~&v[N-1:k];
            // Flush forces every slot to sample an invalid entry.
            assign st_adv[k] = adv[k] | FLUSH;

            if (k == 0) begin : g_head
                assign st_in[k]  = in_xfer;
                assign st_din[k] = DIN;
            end else begin : g_body
                assign st_in[k]  = v[k-1] & ~FLUSH;
                assign st_din[k] = d[k-1];
            end

            elastic_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .CLK     (CLK),
                .RESET   (RESET),
                .adv     (st_adv[k]),
                .in_valid(st_in[k]),
                .din     (st_din[k]),
                .valid   (v[k]),
                .dout    (d[k])
            );
        end

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                occ <= '0;
            end else if (FLUSH) begin
                occ <= '0;
            end else if (in_xfer & ~out_xfer) begin
                occ <= occ + CNT_W'(1);
            end else if (out_xfer & ~in_xfer) begin
                occ <= occ - CNT_W'(1);
            end
        end

        assign OCCUPANCY = occ;
        assign FULL      = (occ == CNT_W'(N));
    end

endmodule
